fft_peak_track: RTL and testbench
=================================

// Module: fft_peak_track
// PURPOSE
//  Parametrised successor to the FFT peak/frequency detector. Consumes one complex
//  FFT frame (re/im per bin, in bin order), forms a per-bin magnitude and tracks the
//  largest bin inside a programmable search window. At frame end it reports peak
//  bin, magnitude and frequency in Hz. Sits directly after the FFT core output port.
// PARAMETERS
//  DW        16       signed width of fft_re / fft_im
//  LOG2_NFFT 11       log2 of FFT length; NFFT = 2**LOG2_NFFT (power of two only)
//  FS_HZ     1000000  sample rate in Hz, used for bin->Hz conversion (<2**32)
//  BIN_LO    1        lowest bin searched (inclusive)
//  BIN_HI    1023     highest bin searched (inclusive), BIN_LO<=BIN_HI<NFFT
//  MAG_MODE  0        0: |re|+|im| ; 1: max(|re|,|im|)+(min(|re|,|im|)>>1)
//  FREQ_W    32       width of freq_hz
// PORTS
//  clk         in   1            clock
//  rst         in   1            asynchronous reset, active-high
//  fft_valid   in   1            bin qualifier, high for a whole frame
//  fft_idx     in   LOG2_NFFT    bin index of current sample
//  fft_re      in   DW           real part, two's complement
//  fft_im      in   DW           imaginary part, two's complement
//  min_level   in   DW+1         peak must strictly exceed this magnitude
//  peak_bin    out  LOG2_NFFT    bin of last accepted peak
//  peak_mag    out  DW+1         magnitude of last accepted peak
//  freq_hz     out  FREQ_W       (peak_bin*FS_HZ)>>LOG2_NFFT, truncated
//  peak_found  out  1            1: last completed frame had a peak > min_level
//  done        out  1            one-cycle pulse per completed frame
//  frame_err   out  1            one-cycle pulse on aborted frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, best_mag=0, best_bin=0. One clock; reset is
//   asynchronous and active-high.
//  Stage 1 (registered, every cycle): |x| is true two's-complement absolute value in DW
//   unsigned bits (-2**(DW-1) -> 2**(DW-1), no saturation); mag per MAG_MODE in DW+1
//   bits; idx, valid, last (=idx==NFFT-1) delayed alongside.
//  FSM states IDLE, SCAN, CALC, DONE:
//   IDLE: fft_valid && fft_idx==0 -> SCAN, best_mag/best_bin cleared. Valid samples
//    with idx!=0 ignored (mid-frame join never starts a frame).
//   SCAN: each staged valid bin with BIN_LO<=idx<=BIN_HI and mag>best_mag (strict)
//    updates best_mag/best_bin; ties keep the lowest bin. Staged last -> CALC.
//    Staged valid low before last -> frame_err pulse, outputs held, -> IDLE.
//   CALC: register prod = best_bin*FS_HZ (LOG2_NFFT+32 bits) -> DONE.
//   DONE: if best_mag>min_level: peak_bin, peak_mag, freq_hz=prod>>LOG2_NFFT updated,
//    peak_found=1; else peak_bin/peak_mag/freq_hz hold, peak_found=0. done pulses
//    one cycle -> IDLE.
//  Latency: done high in the cycle after the 3rd rising edge following the edge that
//   samples bin NFFT-1; outputs valid in that same cycle and held until next update.
//  Inter-frame gap: >=3 idle cycles upstream; an idx 0 arriving in CALC/DONE is
//   ignored and that frame is skipped (no done, no frame_err).
//  Empty window (no bin exceeds 0): best_bin=0, best_mag=0 -> treated as below level.
//  rst asserted mid-frame: immediate return to reset state; partial frame discarded.
// TESTING
//  NFFT=2048,FS=1e6: bin100 re=1000, others 10, min_level=50 -> done, peak_bin=100,
//   peak_mag=1000, freq_hz=48828, peak_found=1, done 3 edges after idx 2047.
//  Equal mag 500 at bins 50 and 60 -> peak_bin=50.
//  mag 30000 at bins 0 and 1500 (outside window), 800 at bin 300 -> peak_bin=300.
//  All bins mag 20, min_level=50 -> done=1, peak_found=0, peak_bin/freq_hz unchanged.
//  fft_valid drops at idx 500 -> frame_err pulse, no done, outputs unchanged; next
//   full frame reports normally.
//  re=-32768,im=0 at bin 7 vs re=32767 at bin 5 -> peak_bin=7, peak_mag=32768; rst
//   pulse mid-frame -> all outputs 0, no done for that frame.

Source files
------------

// File: rtl/fft_peak_track_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_peak_track_if
//  Purpose  : FFT bin stream in, peak report out, for fft_peak_track.
//  Revision : 1.0  initial release
// ============================================================================
interface fft_peak_track_if #(
    parameter int DW        = 16,
    parameter int LOG2_NFFT = 11,
    parameter int FREQ_W    = 32
);
    logic                  fft_valid;
    logic [LOG2_NFFT-1:0]  fft_idx;
    logic signed [DW-1:0]  fft_re;
    logic signed [DW-1:0]  fft_im;
    logic [DW:0]           min_level;
    logic [LOG2_NFFT-1:0]  peak_bin;
    logic [DW:0]           peak_mag;
    logic [FREQ_W-1:0]     freq_hz;
    logic                  peak_found;
    logic                  done;
    logic                  frame_err;

    modport master (
        output fft_valid, fft_idx, fft_re, fft_im, min_level,
        input  peak_bin, peak_mag, freq_hz, peak_found, done, frame_err
    );

    modport slave (
        input  fft_valid, fft_idx, fft_re, fft_im, min_level,
        output peak_bin, peak_mag, freq_hz, peak_found, done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/fft_peak_track.sv
`default_nettype none
// ============================================================================
//  Module   : fft_peak_track
//  Purpose  : Per-bin magnitude, windowed peak search, bin->Hz report per frame.
//  Revision : 1.0  initial release
// ============================================================================
module fft_peak_track #(
    parameter int          DW        = 16,
    parameter int          LOG2_NFFT = 11,
    parameter logic [31:0] FS_HZ     = 32'd1000000,
    parameter int          BIN_LO    = 1,
    parameter int          BIN_HI    = 1023,
    parameter int          MAG_MODE  = 0,
    parameter int          FREQ_W    = 32
) (
    input  wire                  clk,
    input  wire                  rst,
    fft_peak_track_if.slave      bus
);
    localparam int                   c_PW     = LOG2_NFFT + 32;
    localparam logic [LOG2_NFFT-1:0] c_BIN_LO = LOG2_NFFT'(BIN_LO);
    localparam logic [LOG2_NFFT-1:0] c_BIN_HI = LOG2_NFFT'(BIN_HI);
    localparam logic [LOG2_NFFT-1:0] c_LAST   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_CALC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DW-1:0]         w_abs_re;
    logic [DW-1:0]         w_abs_im;
    logic [DW:0]           w_mag;

    logic [DW:0]           r_s1_mag;
    logic [LOG2_NFFT-1:0]  r_s1_idx;
    logic                  r_s1_valid;
    logic                  r_s1_last;

    logic [DW:0]           r_best_mag;
    logic [LOG2_NFFT-1:0]  r_best_bin;
    logic [c_PW-1:0]       r_prod;

    logic                  w_in_win;
    logic                  w_clear;
    logic                  w_upd;
    logic                  w_err;
    logic                  w_prod_ld;
    logic                  w_publish;

    // Negating the most negative value wraps to 2**(DW-1), which is exact when read unsigned
    assign w_abs_re = bus.fft_re[DW-1] ? DW'(-bus.fft_re) : DW'(bus.fft_re);
    assign w_abs_im = bus.fft_im[DW-1] ? DW'(-bus.fft_im) : DW'(bus.fft_im);

    generate
        if (MAG_MODE == 0) begin : g_mag_sum
            assign w_mag = {1'b0, w_abs_re} + {1'b0, w_abs_im};
        end else begin : g_mag_alpha
            logic [DW-1:0] w_hi;
            logic [DW-1:0] w_lo;
            assign w_hi  = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
            assign w_lo  = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
            assign w_mag = {1'b0, w_hi} + {1'b0, w_lo >> 1};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_mag   <= '0;
            r_s1_idx   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_mag   <= w_mag;
            r_s1_idx   <= bus.fft_idx;
            r_s1_valid <= bus.fft_valid;
            r_s1_last  <= (bus.fft_idx == c_LAST);
        end
    end

    assign w_in_win = (r_s1_idx >= c_BIN_LO) && (r_s1_idx <= c_BIN_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_upd     = 1'b0;
        w_err     = 1'b0;
        w_prod_ld = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Frames only start on raw bin 0; mid-frame samples are ignored here
                if (bus.fft_valid && (bus.fft_idx == '0)) begin
                    w_clear = 1'b1;
                    w_next  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!r_s1_valid) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_upd = w_in_win && (r_s1_mag > r_best_mag);
                    if (r_s1_last) begin
                        w_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_prod_ld = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: begin
                w_publish = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_mag     <= '0;
            r_best_bin     <= '0;
            r_prod         <= '0;
            bus.peak_bin   <= '0;
            bus.peak_mag   <= '0;
            bus.freq_hz    <= '0;
            bus.peak_found <= 1'b0;
            bus.done       <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.done      <= w_publish;
            bus.frame_err <= w_err;
            if (w_clear) begin
                r_best_mag <= '0;
                r_best_bin <= '0;
            end else if (w_upd) begin
                r_best_mag <= r_s1_mag;
                r_best_bin <= r_s1_idx;
            end
            if (w_prod_ld) begin
                r_prod <= {{32{1'b0}}, r_best_bin} * {{LOG2_NFFT{1'b0}}, FS_HZ};
            end
            if (w_publish) begin
                if (r_best_mag > bus.min_level) begin
                    bus.peak_bin   <= r_best_bin;
                    bus.peak_mag   <= r_best_mag;
                    bus.freq_hz    <= FREQ_W'(r_prod >> LOG2_NFFT);
                    bus.peak_found <= 1'b1;
                end else begin
                    bus.peak_found <= 1'b0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fft_peak_track.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_peak_track
//  Purpose  : Directed and random frames checked against a windowed-max model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_peak_track;
    localparam int          DW  = 16;
    localparam int          LG  = 11;
    localparam int          N   = 2048;
    localparam int          BLO = 1;
    localparam int          BHI = 1023;
    localparam int          FW  = 32;
    localparam logic [31:0] FS  = 32'd1000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_peak_track_if #(.DW(DW), .LOG2_NFFT(LG), .FREQ_W(FW)) bus ();

    fft_peak_track #(
        .DW(DW), .LOG2_NFFT(LG), .FS_HZ(FS), .BIN_LO(BLO), .BIN_HI(BHI),
        .MAG_MODE(0), .FREQ_W(FW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     re_a [N];
    int     im_a [N];
    int     total = 0;
    int     bad   = 0;
    longint exp_bin, exp_mag, exp_freq, exp_found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: largest |re|+|im| in the window, earliest bin on ties, gated by level
    task automatic model(input int minl);
        int best = 0;
        int bb   = 0;
        for (int b = BLO; b <= BHI; b++) begin
            int m = iabs(re_a[b]) + iabs(im_a[b]);
            if (m > best) begin
                best = m;
                bb   = b;
            end
        end
        if (best > minl) begin
            exp_bin   = bb;
            exp_mag   = best;
            exp_freq  = (longint'(bb) * longint'(FS)) / longint'(N);
            exp_found = 1;
        end else begin
            exp_found = 0;
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < N; i++) begin
            re_a[i] = v;
            im_a[i] = 0;
        end
    endtask

    task automatic drive_bins(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            bus.fft_valid = 1'b1;
            bus.fft_idx   = LG'(i);
            bus.fft_re    = DW'(re_a[i]);
            bus.fft_im    = DW'(im_a[i]);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.fft_valid = 1'b0;
        bus.fft_idx   = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_bin"},   64'(bus.peak_bin),   exp_bin);
        chk({tag, "_mag"},   64'(bus.peak_mag),   exp_mag);
        chk({tag, "_freq"},  64'(bus.freq_hz),    exp_freq);
        chk({tag, "_found"}, 64'(bus.peak_found), exp_found);
    endtask

    // Full frame: done must rise on the 3rd sample point after the last bin
    task automatic run_full(input string tag, input int minl);
        int k    = 0;
        int seen = 0;
        int errs = 0;
        bus.min_level = (DW+1)'(minl);
        drive_bins(0, N-1);
        end_frame();
        model(minl);
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            k++;
            if (bus.frame_err) errs++;
            if (bus.done) seen = 1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 1);
        chk({tag, "_latency"},   64'(k),    3);
        chk({tag, "_no_err"},    64'(errs), 0);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.done), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_quiet(input string tag, input int exp_err);
        int dones = 0;
        int errs  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.frame_err) errs++;
        end
        chk({tag, "_no_done"}, 64'(dones), 0);
        chk({tag, "_err_cnt"}, 64'(errs),  64'(exp_err));
        check_outputs(tag);
    endtask

    initial begin
        bus.fft_valid = 1'b0;
        bus.fft_idx   = '0;
        bus.fft_re    = '0;
        bus.fft_im    = '0;
        bus.min_level = '0;
        rst           = 1'b1;
        exp_bin = 0; exp_mag = 0; exp_freq = 0; exp_found = 0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset_done", 64'(bus.done), 0);
        chk("reset_err",  64'(bus.frame_err), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill(10); re_a[100] = 1000;
        run_full("single_peak", 50);
        chk("single_peak_freq_const", 64'(bus.freq_hz), 48828);

        fill(10); re_a[50] = 500; re_a[60] = 500;
        run_full("tie", 50);

        fill(10); re_a[0] = 30000; re_a[1500] = 30000; re_a[300] = 800;
        run_full("window", 50);

        fill(20);
        run_full("below_level", 50);

        fill(10); re_a[77] = 4000;
        bus.min_level = 17'd50;
        drive_bins(0, 499);
        end_frame();
        expect_quiet("abort", 1);
        run_full("after_abort", 50);

        fill(10); re_a[900] = 9000;
        drive_bins(5, N-1);
        end_frame();
        expect_quiet("mid_join", 0);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f == 0) begin
                    re_a[i] = int'($urandom_range(0, 65535)) - 32768;
                    im_a[i] = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    re_a[i] = int'($urandom_range(0, 200)) - 100;
                    im_a[i] = int'($urandom_range(0, 200)) - 100;
                end
            end
            run_full($sformatf("random%0d", f), int'($urandom_range(0, 240)));
        end

        fill(10); re_a[7] = -32768; re_a[5] = 32767;
        run_full("neg_full", 50);

        drive_bins(0, 999);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_bin = 0; exp_mag = 0; exp_freq = 0; exp_found = 0;
        check_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        drive_bins(1000, N-1);
        end_frame();
        expect_quiet("rst_mid_after", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
